// File: rtl/dfi_dram_responder.sv
// dfi_dram_responder
// Behavioural stand-in for the PHY + DRAM at the DFI boundary, used for
// simulating a memory controller on its own. It decodes DDR commands from
// the control channel, tracks which row each bank has open, stores write beats
// in a byte-masked array and answers read requests a fixed RD_LAT cycles after
// dfi_rddata_en. The first protocol violation is latched in err_valid/err_code.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   dfi_cke, dfi_cs_n           command qualifiers (only cs_n[0] decoded)
//   dfi_ras_n/cas_n/we_n        command encoding
//   dfi_ba, dfi_addr            bank and row/column address
//   dfi_odt                     ignored
//   dfi_wrdata_en/wrdata/mask   write beat (mask bit = 1 keeps the byte)
//   dfi_rddata_en               read beat request
//   dfi_rddata_valid/rddata     read beat response
//   err_valid, err_code         sticky first-error report
//   wr_cnt, rd_cnt              saturating beat counters
`ifndef DRAM_CS_WIDTH
`define DRAM_CS_WIDTH 1
`endif
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_ADDR_WIDTH
`define DRAM_ADDR_WIDTH 14
`endif

module dfi_dram_responder #(
    parameter int CS_W       = `DRAM_CS_WIDTH,
    parameter int BA_W       = `DRAM_BA_WIDTH,
    parameter int ADDR_W     = `DRAM_ADDR_WIDTH,
    parameter int ROW_IDX_W  = 4,
    parameter int COL_IDX_W  = 6,
    parameter int COL_LSB    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dfi_cke,
    input  logic [CS_W-1:0]   dfi_cs_n,
    input  logic              dfi_ras_n,
    input  logic              dfi_cas_n,
    input  logic              dfi_we_n,
    input  logic [BA_W-1:0]   dfi_ba,
    input  logic [ADDR_W-1:0] dfi_addr,
    input  logic              dfi_odt,
    input  logic              dfi_wrdata_en,
    input  logic [127:0]      dfi_wrdata,
    input  logic [15:0]       dfi_wrdata_mask,
    input  logic              dfi_rddata_en,
    output logic              dfi_rddata_valid,
    output logic [127:0]      dfi_rddata,
    output logic              err_valid,
    output logic [2:0]        err_code,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt
);
    localparam int NUM_BANKS = 2**BA_W;
    localparam int IDX_W     = BA_W + ROW_IDX_W + COL_IDX_W;
    localparam int DEPTH     = 2**IDX_W;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    // Enum values equal the {ras_n,cas_n,we_n} encoding so decode is a cast.
    typedef enum logic [2:0] {
        CMD_MRS = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
        CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
    } cmd_t;

    cmd_t cmd;
    assign cmd = (dfi_cke && !dfi_cs_n[0]) ? cmd_t'({dfi_ras_n, dfi_cas_n, dfi_we_n}) : CMD_NOP;

    // Only the row LSBs ever reach the array index, so only they are kept.
    logic [NUM_BANKS-1:0] bank_open_reg;
    logic [ROW_IDX_W-1:0] bank_row_reg [NUM_BANKS];
    logic                 sel_open;
    logic [IDX_W-1:0]     cmd_idx;
    assign sel_open = bank_open_reg[dfi_ba];
    assign cmd_idx  = {dfi_ba, bank_row_reg[dfi_ba], dfi_addr[COL_LSB+COL_IDX_W-1:COL_LSB]};

    // Pending-address FIFOs: index 0 = write, 1 = read.
    logic [1:0]       fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [IDX_W-1:0] fifo_head [2];
    assign fifo_push[0] = (cmd == CMD_WR) && sel_open && !fifo_full[0];
    assign fifo_push[1] = (cmd == CMD_RD) && sel_open && !fifo_full[1];
    // Pops look only at the registered count: no push-to-pop bypass.
    assign fifo_pop[0]  = dfi_wrdata_en && !fifo_empty[0];
    assign fifo_pop[1]  = dfi_rddata_en && !fifo_empty[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [IDX_W-1:0] mem_reg [FIFO_DEPTH];
            logic [PTR_W-1:0] wptr_reg, rptr_reg;
            logic [CNT_W-1:0] count_reg;
            assign fifo_empty[gi] = (count_reg == '0);
            assign fifo_full[gi]  = (count_reg == CNT_W'(FIFO_DEPTH));
            assign fifo_head[gi]  = mem_reg[rptr_reg];
            always_ff @(posedge clk) begin
                if (rst) begin
                    wptr_reg  <= '0;
                    rptr_reg  <= '0;
                    count_reg <= '0;
                end else begin
                    if (fifo_push[gi]) begin
                        mem_reg[wptr_reg] <= cmd_idx;
                        wptr_reg          <= wptr_reg + PTR_W'(1);
                    end
                    if (fifo_pop[gi])
                        rptr_reg <= rptr_reg + PTR_W'(1);
                    count_reg <= count_reg + CNT_W'(fifo_push[gi]) - CNT_W'(fifo_pop[gi]);
                end
            end
        end
    endgenerate

    // Error detection; when several occur in one cycle the lowest code wins.
    logic       err_hit;
    logic [2:0] err_new;
    always_comb begin
        err_hit = 1'b1;
        err_new = 3'd0;
        if ((cmd == CMD_RD || cmd == CMD_WR) && !sel_open)       err_new = 3'd1;
        else if (cmd == CMD_ACT && sel_open)                     err_new = 3'd2;
        else if (cmd == CMD_REF && (|bank_open_reg))             err_new = 3'd3;
        else if (dfi_wrdata_en && fifo_empty[0])                 err_new = 3'd4;
        else if (cmd == CMD_WR && sel_open && fifo_full[0])      err_new = 3'd5;
        else if (dfi_rddata_en && fifo_empty[1])                 err_new = 3'd6;
        else if (cmd == CMD_RD && sel_open && fifo_full[1])      err_new = 3'd7;
        else                                                     err_hit = 1'b0;
    end

    // Bank state. Auto-precharge closes the bank only if the access was queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_open_reg <= '0;
        end else begin
            case (cmd)
                CMD_ACT: begin
                    bank_open_reg[dfi_ba] <= 1'b1;
                    bank_row_reg[dfi_ba]  <= dfi_addr[ROW_IDX_W-1:0];
                end
                CMD_PRE: begin
                    if (dfi_addr[10]) bank_open_reg <= '0;
                    else              bank_open_reg[dfi_ba] <= 1'b0;
                end
                CMD_RD:  if (dfi_addr[10] && fifo_push[1]) bank_open_reg[dfi_ba] <= 1'b0;
                CMD_WR:  if (dfi_addr[10] && fifo_push[0]) bank_open_reg[dfi_ba] <= 1'b0;
                default: ;
            endcase
        end
    end

    // Beat storage: one RAM per byte lane plus a resettable valid bit per entry.
    // The first write to an invalid entry zeroes its masked bytes so that
    // stale RAM contents from before a reset never become visible.
    logic [DEPTH-1:0] valid_reg;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [15:0]      byte_wen;
    logic [127:0]     wr_masked, mem_q, rd_merged;
    assign wr_idx   = fifo_head[0];
    assign rd_idx   = fifo_head[1];
    assign byte_wen = {16{fifo_pop[0]}} & (~dfi_wrdata_mask | {16{!valid_reg[wr_idx]}});

    always_comb begin
        wr_masked = '0;
        for (int b = 0; b < 16; b++)
            wr_masked[b*8 +: 8] = dfi_wrdata_mask[b] ? 8'h00 : dfi_wrdata[b*8 +: 8];
    end

    // Read-side capture at the rddata_en edge (first pipeline stage).
    logic         s1_live_reg, s1_hit_reg, s1_entry_valid_reg;
    logic [15:0]  s1_wen_reg;
    logic [127:0] s1_wdata_reg;

    generate
        for (gi = 0; gi < 16; gi++) begin : g_lane
            logic [7:0] lane_reg [DEPTH];
            logic [7:0] lane_q_reg;
            always_ff @(posedge clk) begin
                if (byte_wen[gi])
                    lane_reg[wr_idx] <= wr_masked[gi*8 +: 8];
                if (fifo_pop[1])
                    lane_q_reg <= lane_reg[rd_idx];
            end
            assign mem_q[gi*8 +: 8] = lane_q_reg;
            // Write-first: a same-cycle write to the read index overrides RAM data.
            assign rd_merged[gi*8 +: 8] = !s1_live_reg ? 8'h00 :
                (s1_hit_reg && s1_wen_reg[gi]) ? s1_wdata_reg[gi*8 +: 8] :
                (s1_entry_valid_reg ? mem_q[gi*8 +: 8] : 8'h00);
        end
    endgenerate

    // Read pipeline: pv_reg[0] is the capture stage, pv_reg[RD_LAT-1] the output.
    logic [RD_LAT-1:0] pv_reg;
    logic [127:0]      pd_reg [1:RD_LAT-1];
    logic              err_valid_reg;
    logic [2:0]        err_code_reg;
    logic [15:0]       wr_cnt_reg, rd_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg     <= '0;
            pv_reg        <= '0;
            s1_live_reg   <= 1'b0;
            s1_hit_reg    <= 1'b0;
            for (int k = 1; k < RD_LAT; k++) pd_reg[k] <= '0;
            err_valid_reg <= 1'b0;
            err_code_reg  <= 3'd0;
            wr_cnt_reg    <= '0;
            rd_cnt_reg    <= '0;
        end else begin
            if (fifo_pop[0]) begin
                valid_reg[wr_idx] <= 1'b1;
                if (wr_cnt_reg != 16'hFFFF) wr_cnt_reg <= wr_cnt_reg + 16'd1;
            end
            // Every rddata_en yields a beat; underflowed requests return zero.
            pv_reg[0]          <= dfi_rddata_en;
            s1_live_reg        <= fifo_pop[1];
            s1_hit_reg         <= fifo_pop[0] && (wr_idx == rd_idx);
            s1_entry_valid_reg <= valid_reg[rd_idx];
            s1_wen_reg         <= byte_wen;
            s1_wdata_reg       <= wr_masked;
            pd_reg[1]          <= rd_merged;
            for (int k = 1; k < RD_LAT; k++) pv_reg[k] <= pv_reg[k-1];
            for (int k = 2; k < RD_LAT; k++) pd_reg[k] <= pd_reg[k-1];
            if (pv_reg[RD_LAT-2] && rd_cnt_reg != 16'hFFFF) rd_cnt_reg <= rd_cnt_reg + 16'd1;
            if (!err_valid_reg && err_hit) begin
                err_valid_reg <= 1'b1;
                err_code_reg  <= err_new;
            end
        end
    end

    assign dfi_rddata_valid = pv_reg[RD_LAT-1];
    assign dfi_rddata       = pd_reg[RD_LAT-1];
    assign err_valid        = err_valid_reg;
    assign err_code         = err_code_reg;
    assign wr_cnt           = wr_cnt_reg;
    assign rd_cnt           = rd_cnt_reg;

    logic unused_sink;
    assign unused_sink = &{1'b0, dfi_odt, dfi_cs_n, dfi_addr, mem_q};
endmodule

// File: tb/tb_dfi_dram_responder.sv
module tb_dfi_dram_responder;
    localparam int RD_LAT = 2;
    localparam int FDEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         dfi_cke;
    logic [0:0]   dfi_cs_n;
    logic         dfi_ras_n, dfi_cas_n, dfi_we_n;
    logic [2:0]   dfi_ba;
    logic [13:0]  dfi_addr;
    logic         dfi_odt;
    logic         dfi_wrdata_en;
    logic [127:0] dfi_wrdata;
    logic [15:0]  dfi_wrdata_mask;
    logic         dfi_rddata_en;
    logic         dfi_rddata_valid;
    logic [127:0] dfi_rddata;
    logic         err_valid;
    logic [2:0]   err_code;
    logic [15:0]  wr_cnt, rd_cnt;

    dfi_dram_responder #(
        .CS_W(1), .BA_W(3), .ADDR_W(14), .ROW_IDX_W(4), .COL_IDX_W(6),
        .COL_LSB(2), .FIFO_DEPTH(FDEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .dfi_cke(dfi_cke), .dfi_cs_n(dfi_cs_n),
        .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n), .dfi_we_n(dfi_we_n),
        .dfi_ba(dfi_ba), .dfi_addr(dfi_addr), .dfi_odt(dfi_odt),
        .dfi_wrdata_en(dfi_wrdata_en), .dfi_wrdata(dfi_wrdata),
        .dfi_wrdata_mask(dfi_wrdata_mask), .dfi_rddata_en(dfi_rddata_en),
        .dfi_rddata_valid(dfi_rddata_valid), .dfi_rddata(dfi_rddata),
        .err_valid(err_valid), .err_code(err_code), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: DRAM behaviour at command level.
    typedef struct { int due; logic [127:0] data; } ret_t;
    bit            m_open [8];
    int            m_row  [8];
    int            m_wq [$];
    int            m_rq [$];
    logic [127:0]  m_mem [int];
    ret_t          m_ret [$];
    bit            m_errv;
    int            m_errc;
    int            m_wrc, m_rdc;
    int            edge_n = 0;
    int            valid_seen = 0;
    logic [127:0]  last_data = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; dfi_cke = 1'b1; dfi_cs_n = 1'b1;
        dfi_ras_n = 1'b1; dfi_cas_n = 1'b1; dfi_we_n = 1'b1;
        dfi_ba = '0; dfi_addr = '0; dfi_odt = 1'b0;
        dfi_wrdata_en = 1'b0; dfi_wrdata = '0; dfi_wrdata_mask = '0;
        dfi_rddata_en = 1'b0;
    endtask

    task automatic note_err(inout int cyc_err, input int code);
        if (cyc_err == 0 || code < cyc_err) cyc_err = code;
    endtask

    // Apply current inputs for one clock, advance the model, compare outputs.
    task automatic step();
        int cerr, wsz, rsz, c, ba, idx;
        bit any;
        logic [127:0] old, nw, rdv;
        logic exp_v;
        logic [127:0] exp_d;
        cerr = 0;
        if (rst) begin
            foreach (m_open[b]) m_open[b] = 0;
            m_wq.delete(); m_rq.delete(); m_mem.delete(); m_ret.delete();
            m_errv = 0; m_errc = 0; m_wrc = 0; m_rdc = 0;
        end else begin
            wsz = m_wq.size(); rsz = m_rq.size();
            c   = (dfi_cke && !dfi_cs_n[0]) ? int'({dfi_ras_n, dfi_cas_n, dfi_we_n}) : 7;
            ba  = int'(dfi_ba);
            if (dfi_wrdata_en) begin
                if (wsz == 0) note_err(cerr, 4);
                else begin
                    idx = m_wq.pop_front();
                    old = m_mem.exists(idx) ? m_mem[idx] : '0;
                    nw  = old;
                    for (int b = 0; b < 16; b++)
                        if (!dfi_wrdata_mask[b]) nw[b*8 +: 8] = dfi_wrdata[b*8 +: 8];
                    m_mem[idx] = nw;
                    if (m_wrc != 16'hFFFF) m_wrc++;
                end
            end
            if (dfi_rddata_en) begin
                rdv = '0;
                if (rsz == 0) note_err(cerr, 6);
                else begin
                    idx = m_rq.pop_front();
                    rdv = m_mem.exists(idx) ? m_mem[idx] : '0;
                end
                m_ret.push_back('{edge_n + RD_LAT, rdv});
            end
            idx = (ba << 10) | ((m_row[ba] & 15) << 6) | ((int'(dfi_addr) >> 2) & 63);
            any = 0;
            foreach (m_open[b]) any |= m_open[b];
            case (c)
                3: begin
                    if (m_open[ba]) note_err(cerr, 2);
                    m_open[ba] = 1; m_row[ba] = int'(dfi_addr);
                end
                5: begin
                    if (!m_open[ba]) note_err(cerr, 1);
                    else if (rsz == FDEPTH) note_err(cerr, 7);
                    else begin m_rq.push_back(idx); if (dfi_addr[10]) m_open[ba] = 0; end
                end
                4: begin
                    if (!m_open[ba]) note_err(cerr, 1);
                    else if (wsz == FDEPTH) note_err(cerr, 5);
                    else begin m_wq.push_back(idx); if (dfi_addr[10]) m_open[ba] = 0; end
                end
                2: begin
                    if (dfi_addr[10]) foreach (m_open[b]) m_open[b] = 0;
                    else m_open[ba] = 0;
                end
                1: if (any) note_err(cerr, 3);
                default: ;
            endcase
            if (!m_errv && cerr != 0) begin m_errv = 1; m_errc = cerr; end
        end
        @(posedge clk); #1;
        edge_n++;
        exp_v = 1'b0; exp_d = '0;
        if (m_ret.size() > 0 && m_ret[0].due == edge_n) begin
            exp_v = 1'b1; exp_d = m_ret[0].data;
            void'(m_ret.pop_front());
            if (m_rdc != 16'hFFFF) m_rdc++;
        end
        chk("rddata_valid", 128'(dfi_rddata_valid), 128'(exp_v));
        chk("rddata", dfi_rddata, exp_d);
        chk("err_valid", 128'(err_valid), 128'(m_errv));
        chk("err_code", 128'(err_code), 128'(m_errc));
        chk("wr_cnt", 128'(wr_cnt), 128'(m_wrc));
        chk("rd_cnt", 128'(rd_cnt), 128'(m_rdc));
        if (dfi_rddata_valid === 1'b1) begin valid_seen++; last_data = dfi_rddata; end
        idle_inputs();
    endtask

    task automatic cmd(input logic [2:0] code, input int ba, input int addr);
        dfi_cs_n = 1'b0;
        {dfi_ras_n, dfi_cas_n, dfi_we_n} = code;
        dfi_ba = 3'(ba); dfi_addr = 14'(addr);
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); rst = 1'b1; step();
    endtask

    int v0;
    int r;

    initial begin
        idle_inputs();
        do_reset();
        chk("reset_valid", 128'(dfi_rddata_valid), 128'(0));
        chk("reset_err", 128'({err_valid, err_code}), 128'(0));

        // Basic write then read back after precharge and re-activate.
        cmd(3'b011, 0, 5); step();
        cmd(3'b100, 0, 8); step();
        dfi_wrdata_en = 1; dfi_wrdata = 128'h0123456789ABCDEF_0123456789ABCDEF; step();
        cmd(3'b010, 0, 0); step();
        cmd(3'b011, 0, 5); step();
        cmd(3'b101, 0, 8); step();
        v0 = valid_seen;
        dfi_rddata_en = 1; step();
        chk("lat_n+1", 128'(valid_seen - v0), 128'(0));
        step();
        chk("lat_n+2", 128'(valid_seen - v0), 128'(1));
        chk("tp1_data", last_data, 128'h0123456789ABCDEF_0123456789ABCDEF);
        chk("tp1_cnt", 128'({wr_cnt, rd_cnt}), 128'({16'd1, 16'd1}));

        // Byte mask over an all-ones location.
        cmd(3'b100, 0, 16); step();
        dfi_wrdata_en = 1; dfi_wrdata = '1; step();
        cmd(3'b100, 0, 16); step();
        dfi_wrdata_en = 1; dfi_wrdata = '0; dfi_wrdata_mask = 16'h00FF; step();
        cmd(3'b101, 0, 16); step();
        dfi_rddata_en = 1; step();
        step(); step();
        chk("tp2_mask", last_data, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF});

        // Unwritten location, then back-to-back reads.
        cmd(3'b101, 0, 40); step();
        dfi_rddata_en = 1; step();
        step(); step();
        chk("tp3_unwritten", last_data, 128'h0);
        v0 = valid_seen;
        cmd(3'b101, 0, 8); step();
        for (int i = 0; i < 3; i++) begin cmd(3'b101, 0, 40); dfi_rddata_en = 1; step(); end
        dfi_rddata_en = 1; step();
        step(); step();
        chk("tp3_b2b", 128'(valid_seen - v0), 128'(4));
        chk("tp3_last", last_data, 128'h0);

        // Access to closed bank; later errors do not overwrite the code.
        do_reset();
        cmd(3'b101, 3, 0); step();
        chk("tp4_code1", 128'({err_valid, err_code}), 128'({1'b1, 3'd1}));
        cmd(3'b011, 0, 1); step();
        cmd(3'b011, 0, 2); step();
        chk("tp4_sticky", 128'(err_code), 128'(1));

        // Write FIFO overflow, then underflow in a fresh run.
        do_reset();
        cmd(3'b011, 0, 0); step();
        for (int i = 0; i < 5; i++) begin cmd(3'b100, 0, i * 4); step(); end
        chk("tp5_overflow", 128'(err_code), 128'(5));
        do_reset();
        dfi_wrdata_en = 1; step();
        chk("tp5_underflow", 128'(err_code), 128'(4));

        // Reset discards an in-flight read.
        do_reset();
        cmd(3'b011, 1, 0); step();
        cmd(3'b101, 1, 0); step();
        v0 = valid_seen;
        dfi_rddata_en = 1; step();
        rst = 1; step();
        step(); step(); step();
        chk("tp6_no_valid", 128'(valid_seen - v0), 128'(0));
        chk("tp6_outputs", 128'({dfi_rddata_valid, err_valid, err_code, wr_cnt, rd_cnt}), 128'(0));
        cmd(3'b101, 1, 0); step();
        chk("tp6_closed", 128'(err_code), 128'(1));

        // Randomized traffic against the model, with periodic resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) do_reset();
            dfi_cke = ($urandom_range(0, 19) != 0);
            r = $urandom_range(0, 99);
            if (r < 20)      cmd(3'b011, $urandom_range(0, 3), $urandom_range(0, 16383));
            else if (r < 40) cmd(3'b101, $urandom_range(0, 3), ($urandom_range(0, 3) << 2) | (($urandom_range(0, 3) == 0) << 10));
            else if (r < 60) cmd(3'b100, $urandom_range(0, 3), ($urandom_range(0, 3) << 2) | (($urandom_range(0, 3) == 0) << 10));
            else if (r < 75) cmd(3'b010, $urandom_range(0, 3), ($urandom_range(0, 2) == 0) << 10);
            else if (r < 78) cmd(3'b001, 0, 0);
            else if (r < 80) cmd(3'($urandom_range(0, 1) * 6), 0, 0);
            if ($urandom_range(0, 9) == 0) dfi_cs_n = 1'b1;
            dfi_wrdata_en   = ($urandom_range(0, 2) == 0);
            dfi_wrdata      = {$urandom, $urandom, $urandom, $urandom};
            dfi_wrdata_mask = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
            dfi_rddata_en   = ($urandom_range(0, 2) == 0);
            dfi_odt         = 1'($urandom);
            step();
        end
        for (int i = 0; i < 4; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dfi_dram_responder.md
Name: dfi_dram_responder

Overview:
- DFI-level DRAM behavioural responder for controller-only simulation. It sits at the destination end of the DFI control, write and read channels, in place of the PHY and DRAM.
- Decodes DDR commands, tracks per-bank open rows, stores write beats in a byte-masked sparse array, and returns read data with rddata_valid a fixed latency after rddata_en.
- Flags DFI and DRAM protocol violations.

Parameters:
- CS_W, `DRAM_CS_WIDTH, chip-select width; only bit 0 is decoded.
- BA_W, `DRAM_BA_WIDTH, bank address width; NUM_BANKS = 2**BA_W.
- ADDR_W, `DRAM_ADDR_WIDTH, row/column address width.
- ROW_IDX_W, 4, row LSBs used in the array index.
- COL_IDX_W, 6, column bits used in the array index.
- COL_LSB, 2, lowest column bit used (beat granularity).
- FIFO_DEPTH, 4, entries in each pending-address FIFO (power of 2).
- RD_LAT, 2, cycles from rddata_en to rddata_valid (legal range ≥ 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- dfi_cke  in  1  clock enable.
- dfi_cs_n  in  CS_W  chip select, active-low.
- dfi_ras_n  in  1  RAS, active-low.
- dfi_cas_n  in  1  CAS, active-low.
- dfi_we_n  in  1  WE, active-low.
- dfi_ba  in  BA_W  bank address.
- dfi_addr  in  ADDR_W  row or column address.
- dfi_odt  in  1  on-die termination; ignored.
- dfi_wrdata_en  in  1  write beat present.
- dfi_wrdata  in  128  write beat, [127:64] first half.
- dfi_wrdata_mask  in  16  byte mask; 1 = byte not written.
- dfi_rddata_en  in  1  read beat request.
- dfi_rddata_valid  out  1  read beat valid.
- dfi_rddata  out  128  read beat.
- err_valid  out  1  sticky: a protocol error occurred.
- err_code  out  3  code of the first error.
- wr_cnt  out  16  saturating count of written beats.
- rd_cnt  out  16  saturating count of returned beats.

Behaviour:
- Reset: all outputs are 0. Reset also clears bank states (all closed), both FIFOs, the read pipeline, all array valid bits and the error state. Reset mid-burst discards in-flight reads; no rddata_valid appears after reset.
- Command sampling:
  - A command is sampled at posedge when dfi_cke=1 and dfi_cs_n[0]=0; otherwise the cycle is a NOP.
  - {ras_n,cas_n,we_n} decode: 011 ACT, 101 RD, 100 WR, 010 PRE, 001 REF, 000 MRS (ignored), 110 BST (ignored), 111 NOP.
- Per-bank state (CLOSED/OPEN plus row register):
  - ACT: CLOSED→OPEN, row = dfi_addr.
  - PRE with addr[10]=1: all banks→CLOSED. PRE with addr[10]=0: bank dfi_ba→CLOSED. PRE to a closed bank is legal.
  - RD/WR with addr[10]=1 (auto-precharge): the bank closes after the access is queued.
- Array index = {ba, openrow[ROW_IDX_W-1:0], addr[COL_LSB+COL_IDX_W-1:COL_LSB]}. Each RD/WR is exactly one 128-bit beat.
- WR path:
  - A WR command pushes its index to the write FIFO.
  - Each dfi_wrdata_en cycle pops one index and writes the unmasked bytes at that posedge, then sets the entry's valid bit and increments wr_cnt.
- RD path:
  - A RD command pushes its index to the read FIFO.
  - Each dfi_rddata_en cycle pops one index and reads the array. An invalid entry reads as 0.
  - Data passes through an RD_LAT-stage pipeline: rddata_en at cycle N gives rddata_valid=1 with data at cycle N+RD_LAT. rd_cnt increments on valid.
  - dfi_rddata is 0 whenever rddata_valid=0. Back-to-back rddata_en gives back-to-back valid.
- Simultaneous events:
  - Push and pop in the same cycle: both occur. An empty FIFO popped in the same cycle as a push is still an underflow (no bypass).
  - A read pop and a write pop to the same index in the same cycle: read data reflects the new write (write-first).
- Errors: the first error latches err_valid=1 and err_code; later errors are ignored until reset. Codes:
  - 1: RD/WR to a CLOSED bank; command dropped.
  - 2: ACT to an OPEN bank; row overwritten.
  - 3: REF with any bank OPEN.
  - 4: wrdata_en with write FIFO empty; beat dropped.
  - 5: WR with write FIFO full; command dropped.
  - 6: rddata_en with read FIFO empty; returns 0 with valid.
  - 7: RD with read FIFO full; command dropped.
- Counters saturate at 16'hFFFF.

Test Plan:
- ACT b0 row 5; WR b0 col 8; wrdata_en with data 0x0123..EF and mask 0; PRE; ACT b0 row 5; RD col 8; rddata_en at cycle N → rddata_valid at N+2, data 0x0123..EF, wr_cnt=1, rd_cnt=1.
- WR with mask 16'h00FF over a location holding all-ones, new data 0 → read returns {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}.
- RD to never-written location, then 4 back-to-back RD + rddata_en → 4 consecutive valid cycles, unwritten beat = 0.
- RD to bank 3 with no ACT → err_valid=1, err_code=1, no FIFO push. A later ACT to an open bank leaves err_code=1.
- 5 WR commands without wrdata_en (FIFO_DEPTH=4) → err_code=5. A fresh run with wrdata_en and empty FIFO → err_code=4.
- rddata_en pulse then rst=1 at the next cycle → no rddata_valid, all outputs 0, a post-reset RD to the same bank → err_code=1.
